// File: rtl/switch_allocator_wh_pkg.sv
// Shared configuration for the wormhole switch allocator: port count,
// port index names and the per-output allocation state type.
package switch_allocator_wh_pkg;

    // Number of router ports: port 0 is local, 1..N-1 are neighbours.
    localparam int N_PORTS = 5;

    // Port index names.
    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    // Per-output allocation state: free for arbitration, or held by a packet.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_e;

endpackage

// File: rtl/switch_allocator_wh_rr_arbiter_n.sv
// Round-robin arbiter: grants the first requester found at or after ptr,
// searching cyclically and wrapping from N-1 back to 0.
module rr_arbiter_n
    import switch_allocator_wh_pkg::*;
#(
    parameter int N     = N_PORTS,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any_gnt
);

    int w_idx;

    // Cyclic priority search starting at ptr; the first hit wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_gnt    = 1'b0;
        w_idx      = 0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                w_idx = int'(ptr) + k;
                if (w_idx >= N) begin
                    w_idx = w_idx - N;
                end
                if (!any_gnt && req[w_idx]) begin
                    any_gnt           = 1'b1;
                    gnt_onehot[w_idx] = 1'b1;
                    gnt_idx           = w_idx[SEL_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/switch_allocator_wh.sv
// Wormhole switch allocator. Each output port arbitrates round-robin among
// inputs requesting it, then stays locked to the winning input until that
// packet's tail flit crosses.
//
// Handshake: a flit at input i moves to output j in a cycle exactly when
// i_flit_valid[i], the (qualified) request for j and i_out_ready[j] are all
// high and j picks i; that cycle o_input_grant[i] (pop) and o_output_valid[j]
// are both high. Grants are combinational; state moves on the next clk edge.
module switch_allocator_wh
    import switch_allocator_wh_pkg::*;
#(
    parameter int N     = N_PORTS,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [0:N-1][0:N-1]        i_output_req,
    input  logic [0:N-1]               i_flit_valid,
    input  logic [0:N-1]               i_flit_tail,
    input  logic [0:N-1]               i_out_ready,
    output logic [0:N-1]               o_input_grant,
    output logic [0:N-1]               o_output_valid,
    output logic [0:N-1][SEL_W-1:0]    o_xbar_sel,
    output logic [0:N-1]               o_locked
);

    alloc_state_e     r_state   [N];
    logic [SEL_W-1:0] r_owner   [N];
    logic [SEL_W-1:0] r_rr_ptr  [N];

    alloc_state_e     w_state_nxt [N];
    logic [SEL_W-1:0] w_owner_nxt [N];
    logic [SEL_W-1:0] w_rr_nxt    [N];

    logic [N-1:0]     w_sel_req   [N];  // per input: lowest set request bit only
    logic [N-1:0]     w_req       [N];  // per output: qualified requesters
    logic [N-1:0]     w_arb_onehot[N];
    logic [SEL_W-1:0] w_arb_idx   [N];
    logic             w_arb_any   [N];
    logic             w_arb_en    [N];

    // Reduce each input's request to its lowest-index set bit.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_sel_req[i] = '0;
            for (int j = N - 1; j >= 0; j--) begin
                if (i_output_req[i][j]) begin
                    w_sel_req[i]    = '0;
                    w_sel_req[i][j] = 1'b1;
                end
            end
        end
    end

    // Transpose to per-output request vectors; U-turn requests are dropped.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_req[j]    = '0;
            w_arb_en[j] = reset_n && i_out_ready[j] && (r_state[j] == IDLE);
            for (int i = 0; i < N; i++) begin
                w_req[j][i] = i_flit_valid[i] && w_sel_req[i][j] && (i != j);
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_arb
            rr_arbiter_n #(.N(N), .SEL_W(SEL_W)) u_arb (
                .req        (w_req[g]),
                .ptr        (r_rr_ptr[g]),
                .en         (w_arb_en[g]),
                .gnt_onehot (w_arb_onehot[g]),
                .gnt_idx    (w_arb_idx[g]),
                .any_gnt    (w_arb_any[g])
            );
        end
    endgenerate

    // Per-output next state and grant outputs: owner path when locked, arbiter when idle.
    always_comb begin
        o_input_grant  = '0;
        o_output_valid = '0;
        o_xbar_sel     = '0;
        o_locked       = '0;
        for (int j = 0; j < N; j++) begin
            w_state_nxt[j] = r_state[j];
            w_owner_nxt[j] = r_owner[j];
            w_rr_nxt[j]    = r_rr_ptr[j];
            if (r_state[j] == LOCKED) begin
                o_locked[j] = 1'b1;
                if (w_req[j][r_owner[j]] && i_out_ready[j]) begin
                    o_output_valid[j]         = 1'b1;
                    o_xbar_sel[j]             = r_owner[j];
                    o_input_grant[r_owner[j]] = 1'b1;
                    if (i_flit_tail[r_owner[j]]) begin
                        w_state_nxt[j] = IDLE;
                    end
                end
            end else if (w_arb_any[j]) begin
                o_output_valid[j]          = 1'b1;
                o_xbar_sel[j]              = w_arb_idx[j];
                o_input_grant[w_arb_idx[j]] = 1'b1;
                w_rr_nxt[j] = (w_arb_idx[j] == SEL_W'(N - 1)) ? '0 : w_arb_idx[j] + 1'b1;
                if (!i_flit_tail[w_arb_idx[j]]) begin
                    w_state_nxt[j] = LOCKED;
                    w_owner_nxt[j] = w_arb_idx[j];
                end
            end
        end
        if (!reset_n) begin
            o_input_grant  = '0;
            o_output_valid = '0;
            o_xbar_sel     = '0;
            o_locked       = '0;
        end
    end

    // State registers; reset drops any lock without draining the packet.
    always_ff @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (!reset_n) begin
                r_state[j]  <= IDLE;
                r_owner[j]  <= '0;
                r_rr_ptr[j] <= '0;
            end else begin
                r_state[j]  <= w_state_nxt[j];
                r_owner[j]  <= w_owner_nxt[j];
                r_rr_ptr[j] <= w_rr_nxt[j];
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator_wh.sv
// Bench for switch_allocator_wh: directed scenarios followed by random
// packet traffic, all checked every cycle against a behavioural model.
module tb_switch_allocator_wh;
    import switch_allocator_wh_pkg::*;

    localparam int N     = N_PORTS;
    localparam int SEL_W = $clog2(N);

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [0:N-1][0:N-1]     i_output_req;
    logic [0:N-1]            i_flit_valid;
    logic [0:N-1]            i_flit_tail;
    logic [0:N-1]            i_out_ready;
    logic [0:N-1]            o_input_grant;
    logic [0:N-1]            o_output_valid;
    logic [0:N-1][SEL_W-1:0] o_xbar_sel;
    logic [0:N-1]            o_locked;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per output, locked flag, owner and next-priority input.
    bit           m_locked [N];
    int           m_owner  [N];
    int           m_ptr    [N];
    logic [0:N-1] e_grant, e_valid, e_locked;
    int           e_sel    [N];

    // Random traffic generator state per input.
    int dest [N];
    int rem  [N];
    int age  [N];

    switch_allocator_wh #(.N(N), .SEL_W(SEL_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_output_req   (i_output_req),
        .i_flit_valid   (i_flit_valid),
        .i_flit_tail    (i_flit_tail),
        .i_out_ready    (i_out_ready),
        .o_input_grant  (o_input_grant),
        .o_output_valid (o_output_valid),
        .o_xbar_sel     (o_xbar_sel),
        .o_locked       (o_locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Destination an input effectively asks for: lowest set bit, -1 if none.
    function automatic int first_bit(input int i);
        for (int j = 0; j < N; j++) begin
            if (i_output_req[i][j]) return j;
        end
        return -1;
    endfunction

    // Expected outputs for the current inputs and model state.
    task automatic model_eval();
        int best, bestd, d, o;
        e_grant  = '0;
        e_valid  = '0;
        e_locked = '0;
        for (int j = 0; j < N; j++) begin
            e_sel[j] = 0;
            if (reset_n !== 1'b1) continue;
            if (m_locked[j]) begin
                e_locked[j] = 1'b1;
                o = m_owner[j];
                if (i_flit_valid[o] && first_bit(o) == j && i_out_ready[j]) begin
                    e_valid[j] = 1'b1;
                    e_sel[j]   = o;
                    e_grant[o] = 1'b1;
                end
            end else if (i_out_ready[j]) begin
                best  = -1;
                bestd = N;
                for (int i = 0; i < N; i++) begin
                    if (i != j && i_flit_valid[i] && first_bit(i) == j) begin
                        d = (i - m_ptr[j] + N) % N;
                        if (d < bestd) begin
                            bestd = d;
                            best  = i;
                        end
                    end
                end
                if (best >= 0) begin
                    e_valid[j]    = 1'b1;
                    e_sel[j]      = best;
                    e_grant[best] = 1'b1;
                end
            end
        end
    endtask

    // Advance the model across one clock edge.
    task automatic model_update();
        for (int j = 0; j < N; j++) begin
            if (reset_n !== 1'b1) begin
                m_locked[j] = 1'b0;
                m_owner[j]  = 0;
                m_ptr[j]    = 0;
            end else if (e_valid[j]) begin
                if (!m_locked[j]) begin
                    m_ptr[j] = (e_sel[j] + 1) % N;
                    if (!i_flit_tail[e_sel[j]]) begin
                        m_locked[j] = 1'b1;
                        m_owner[j]  = e_sel[j];
                    end
                end else if (i_flit_tail[m_owner[j]]) begin
                    m_locked[j] = 1'b0;
                end
            end
        end
    endtask

    // One cycle: inputs already driven; compare after settling, then clock.
    task automatic step();
        #1;
        model_eval();
        chk("input_grant", o_input_grant, e_grant);
        chk("output_valid", o_output_valid, e_valid);
        chk("locked", o_locked, e_locked);
        for (int j = 0; j < N; j++) begin
            if (e_valid[j]) chk($sformatf("xbar_sel[%0d]", j), o_xbar_sel[j], e_sel[j]);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_output_req = '0;
        i_flit_valid = '0;
        i_flit_tail  = '0;
        i_out_ready  = '1;
    endtask

    task automatic drive(input int i, input int j, input bit tail);
        i_output_req[i]    = '0;
        i_output_req[i][j] = 1'b1;
        i_flit_valid[i]    = 1'b1;
        i_flit_tail[i]     = tail;
    endtask

    initial begin
        int sel_seq [4];
        sel_seq = '{1, 3, 4, 1};
        for (int j = 0; j < N; j++) begin
            m_locked[j] = 1'b0; m_owner[j] = 0; m_ptr[j] = 0;
            dest[j] = 0; rem[j] = 0; age[j] = 0;
        end

        // Reset held two cycles with every input asking for output 2.
        reset_n = 1'b0;
        clear_inputs();
        for (int i = 0; i < N; i++) drive(i, 2, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("reset_outputs_zero", {o_input_grant, o_output_valid, o_locked}, '0);
            step();
        end
        reset_n = 1'b1;
        #1;
        chk("first_grant_in0", o_input_grant[0], 1'b1);
        chk("first_sel_out2", o_xbar_sel[2], 0);
        step();

        // Round-robin among inputs 1, 3, 4 on output 2.
        clear_inputs();
        drive(1, 2, 1'b1); drive(3, 2, 1'b1); drive(4, 2, 1'b1);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rr_sel_out2", o_xbar_sel[2], sel_seq[c]);
            step();
        end

        // Wormhole lock: 4-flit packet 1->3 while input 4 waits for output 3.
        clear_inputs();
        drive(4, 3, 1'b1);
        for (int c = 0; c < 4; c++) begin
            drive(1, 3, c == 3);
            #1;
            chk("wh_sel_out3", o_xbar_sel[3], 1);
            chk("wh_in4_held", o_input_grant[4], 1'b0);
            chk("wh_locked_out3", o_locked[3], c >= 1);
            step();
        end
        i_flit_valid[1] = 1'b0;
        #1;
        chk("wh_in4_after", o_input_grant[4], 1'b1);
        step();

        // Backpressure and bubble while output 1 is locked to input 2.
        clear_inputs();
        drive(3, 1, 1'b1);
        drive(2, 1, 1'b0);
        step();
        i_out_ready[1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("bp_no_valid", o_output_valid[1], 1'b0);
            chk("bp_lock_holds", o_locked[1], 1'b1);
            step();
        end
        i_out_ready[1]  = 1'b1;
        i_flit_valid[2] = 1'b0;
        #1;
        chk("bubble_no_valid", o_output_valid[1], 1'b0);
        chk("bubble_in3_held", o_input_grant[3], 1'b0);
        step();
        for (int c = 0; c < 2; c++) begin
            drive(2, 1, c == 1);
            #1;
            chk("bp_body_sel", o_xbar_sel[1], 2);
            step();
        end
        i_flit_valid[2] = 1'b0;
        #1;
        chk("bp_in3_after", o_input_grant[3], 1'b1);
        step();

        // Parallel outputs and a U-turn request.
        clear_inputs();
        drive(0, 1, 1'b1); drive(1, 0, 1'b1); drive(2, 2, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("par_grants", o_input_grant, 5'b11000);
            step();
        end

        // Reset while output 4 is locked to input 3.
        clear_inputs();
        drive(3, 4, 1'b0);
        step();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        drive(1, 4, 1'b1);
        #1;
        chk("rst_mid_unlocked", o_locked[4], 1'b0);
        chk("rst_mid_sel", o_xbar_sel[4], 1);
        step();

        // Random packet traffic with bubbles, backpressure and multi-bit requests.
        clear_inputs();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) != 0) begin
                    dest[i] = $urandom_range(0, N - 1);
                    rem[i]  = $urandom_range(1, 4);
                    age[i]  = 0;
                end
                i_output_req[i] = '0;
                if (rem[i] > 0) begin
                    i_output_req[i][dest[i]] = 1'b1;
                    for (int k = dest[i] + 1; k < N; k++) begin
                        if ($urandom_range(0, 5) == 0) i_output_req[i][k] = 1'b1;
                    end
                end
                i_flit_valid[i] = (rem[i] > 0) && ($urandom_range(0, 7) != 0);
                i_flit_tail[i]  = (rem[i] == 1);
            end
            for (int j = 0; j < N; j++) i_out_ready[j] = ($urandom_range(0, 4) != 0);
            reset_n = ($urandom_range(0, 199) != 0);
            step();
            for (int i = 0; i < N; i++) begin
                if (e_grant[i]) begin
                    rem[i]--;
                    age[i] = 0;
                end else if (rem[i] > 0 && ++age[i] > 30) begin
                    rem[i] = 0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
